ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 150 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: parses a PS/2 set-2 byte stream (E0/F0 prefixes) into key events with
// ASCII mapping, held-key/typematic detection, shift/caps state and a press counter.
module ps2_scancode_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic [7:0]       key_ascii,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count,
    output logic             shift_on,
    output logic             caps_on,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;

    state_t     state, state_nx;
    logic       brk_ext, brk_ext_nx;
    logic       cap, emit, emit_ext, emit_brk, bad;
    logic       is_e0, is_f0, is_mod, make, rpt, held_hit;
    logic       shift_l, shift_r, held_ext;
    logic [7:0] held_code;

    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        // only letters sit at or above 0x61, so case folding never touches digits or controls
        return (up && a >= 8'h61) ? a - 8'h20 : a;
    endfunction

    assign cap      = ps2_ready & nextdata_n;
    assign is_e0    = ps2_data == 8'hE0;
    assign is_f0    = ps2_data == 8'hF0;
    assign shift_on = shift_l | shift_r;
    assign is_mod   = !emit_ext && (ps2_data == 8'h12 || ps2_data == 8'h59 || ps2_data == 8'h58);
    assign make     = emit && !emit_brk;
    assign held_hit = held_code == ps2_data && held_ext == emit_ext;
    assign rpt      = make && key_down && held_hit;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            brk_ext <= 1'b0;
        end else begin
            state   <= state_nx;
            brk_ext <= brk_ext_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        brk_ext_nx = brk_ext;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        bad        = 1'b0;
        if (cap) begin
            case (state)
                IDLE: begin
                    state_nx   = is_e0 ? EXT : is_f0 ? BRK : IDLE;
                    brk_ext_nx = 1'b0;
                    emit       = !is_e0 && !is_f0;
                end
                EXT: begin
                    state_nx   = is_f0 ? BRK : is_e0 ? EXT : IDLE;
                    brk_ext_nx = 1'b1;
                    bad        = is_e0;
                    emit       = !is_e0 && !is_f0;
                    emit_ext   = 1'b1;
                end
                BRK: begin
                    state_nx = IDLE;
                    bad      = is_e0 || is_f0;
                    emit     = !is_e0 && !is_f0;
                    emit_ext = brk_ext;
                    emit_brk = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n  <= 1'b1;
            key_valid   <= 1'b0;
            err         <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            key_ascii   <= 8'h00;
            key_down    <= 1'b0;
            press_count <= '0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            caps_on     <= 1'b0;
        end else begin
            // a pop cycle always follows a capture, and the edge ending it ignores ps2_ready
            nextdata_n <= !cap;
            key_valid  <= emit;
            err        <= bad;
            if (emit) begin
                key_code   <= ps2_data;
                key_ext    <= emit_ext;
                key_break  <= emit_brk;
                key_repeat <= rpt;
                key_ascii  <= emit_ext ? 8'h00 : to_ascii(ps2_data, shift_on ^ caps_on);
            end
            if (make && !rpt)
                press_count <= press_count + CNT_W'(1);
            if (make && !is_mod) begin
                held_code <= ps2_data;
                held_ext  <= emit_ext;
                key_down  <= 1'b1;
            end
            if (emit && emit_brk && held_hit)
                key_down <= 1'b0;
            if (emit && is_mod && ps2_data == 8'h12)
                shift_l <= !emit_brk;
            if (emit && is_mod && ps2_data == 8'h59)
                shift_r <= !emit_brk;
            if (make && !rpt && is_mod && ps2_data == 8'h58)
                caps_on <= !caps_on;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: randomized and directed byte streams scored against a prefix-queue
// reference model; a second instance with CNT_W=2 checks counter wrap.
module tb_ps2_scancode_decoder;
    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext, brk, rpt;
        logic [7:0] ascii;
        logic       down;
        logic [7:0] cnt;
        logic       shift, caps;
    } ev_t;

    logic clk = 1'b0, clrn = 1'b1;
    logic [7:0] ps2_data = 8'h00;
    logic ps2_ready = 1'b0;
    logic nextdata_n, key_valid, key_ext, key_break, key_repeat, key_down, shift_on, caps_on, err;
    logic [7:0] key_code, key_ascii, press_count;
    logic b_nextdata_n, b_key_valid, b_key_ext, b_key_break, b_key_repeat, b_key_down;
    logic b_shift_on, b_caps_on, b_err;
    logic [7:0] b_key_code, b_key_ascii;
    logic [1:0] b_press_count;

    int checks = 0, fails = 0, n_err = 0;
    logic [7:0] fifo[$];
    logic [7:0] pfx[$];
    ev_t exq[$];
    bit m_down, m_held_ext, m_sl, m_sr, m_caps;
    logic [7:0] m_held;
    int m_cnt;

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] mod_sc [3] = '{8'h12, 8'h59, 8'h58};

    ps2_scancode_decoder dut (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .key_repeat(key_repeat), .key_ascii(key_ascii), .key_down(key_down),
        .press_count(press_count), .shift_on(shift_on), .caps_on(caps_on), .err(err)
    );

    ps2_scancode_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(b_nextdata_n), .key_valid(b_key_valid), .key_code(b_key_code),
        .key_ext(b_key_ext), .key_break(b_key_break), .key_repeat(b_key_repeat),
        .key_ascii(b_key_ascii), .key_down(b_key_down), .press_count(b_press_count),
        .shift_on(b_shift_on), .caps_on(b_caps_on), .err(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, a, x, $time);
        end
    endtask

    function automatic bit pfx_has(input logic [7:0] b);
        foreach (pfx[i]) if (pfx[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == c) return 8'h30 + 8'(i);
        return c == 8'h29 ? 8'h20 : c == 8'h5A ? 8'h0D : 8'h00;
    endfunction

    // Reference: collect prefixes until a code byte arrives, then apply the key-event rules.
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        bit is_mod;
        e = '0;
        if (b == 8'hE0 || b == 8'hF0) begin
            if (pfx_has(8'hF0)) begin
                e.err = 1'b1;
                pfx.delete();
                exq.push_back(e);
            end else if (b == 8'hE0 && pfx_has(8'hE0)) begin
                e.err = 1'b1;
                exq.push_back(e);
            end else
                pfx.push_back(b);
            return;
        end
        e.ext = pfx_has(8'hE0);
        e.brk = pfx_has(8'hF0);
        pfx.delete();
        e.code = b;
        e.ascii = e.ext ? 8'h00 : ref_ascii(b, (m_sl | m_sr) ^ m_caps);
        is_mod = !e.ext && (b == 8'h12 || b == 8'h59 || b == 8'h58);
        if (!e.brk) begin
            e.rpt = m_down && m_held == b && m_held_ext == e.ext;
            if (!e.rpt) m_cnt++;
            if (!is_mod) begin
                m_held = b;
                m_held_ext = e.ext;
                m_down = 1'b1;
            end
            if (is_mod && b == 8'h12) m_sl = 1'b1;
            if (is_mod && b == 8'h59) m_sr = 1'b1;
            if (is_mod && b == 8'h58 && !e.rpt) m_caps = !m_caps;
        end else begin
            if (m_held == b && m_held_ext == e.ext) m_down = 1'b0;
            if (is_mod && b == 8'h12) m_sl = 1'b0;
            if (is_mod && b == 8'h59) m_sr = 1'b0;
        end
        e.down = m_down;
        e.cnt = 8'(m_cnt);
        e.shift = m_sl | m_sr;
        e.caps = m_caps;
        exq.push_back(e);
    endtask

    task automatic model_reset();
        pfx.delete();
        m_down = 0; m_held_ext = 0; m_sl = 0; m_sr = 0; m_caps = 0; m_held = 8'h00; m_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((fifo.size() != 0 || !nextdata_n) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout fifo=%0d nextdata_n=%0b", fifo.size(), nextdata_n);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_outputs", {key_valid, key_ext, key_break, key_repeat, key_down, shift_on, caps_on,
            err, key_code, key_ascii, press_count}, 32'h0);
        chk("rst_nextdata_n", nextdata_n, 1'b1);
        chk("rst_outputs_cnt2", {b_key_valid, b_key_down, b_shift_on, b_caps_on, b_err,
            b_key_code, b_key_ascii, b_press_count}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // Receiver FIFO: pops on the rising edge that ends a nextdata_n=0 cycle.
    initial begin : fifo_drv
        logic nd;
        forever begin
            @(negedge clk);
            nd = nextdata_n;
            @(posedge clk);
            #1;
            if (!nd && fifo.size() > 0) void'(fifo.pop_front());
            ps2_ready = fifo.size() > 0;
            ps2_data = fifo.size() > 0 ? fifo[0] : 8'h00;
        end
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (key_valid || err) begin
                if (err) n_err++;
                if (exq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event key_valid=%0b err=%0b", key_valid, err);
                end else begin
                    e = exq.pop_front();
                    chk("err", err, e.err);
                    chk("key_valid", key_valid, !e.err);
                    chk("pop_same_cycle", nextdata_n, 1'b0);
                    if (!e.err) begin
                        chk("key_code", key_code, e.code);
                        chk("key_ext", key_ext, e.ext);
                        chk("key_break", key_break, e.brk);
                        chk("key_repeat", key_repeat, e.rpt);
                        chk("key_ascii", key_ascii, e.ascii);
                        chk("key_down", key_down, e.down);
                        chk("press_count", press_count, e.cnt);
                        chk("press_count_w2", b_press_count, e.cnt[1:0]);
                        chk("shift_on", shift_on, e.shift);
                        chk("caps_on", caps_on, e.caps);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] cb, b, last;
        logic [1:0] bb;
        int lows, cons, r, e0;
        logic prev;
        model_reset();
        #2 clrn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        clrn = 1'b1;

        send(8'h1C);
        wait_idle();
        chk("make_code", key_code, 8'h1C);
        chk("make_ascii", key_ascii, 8'h61);
        chk("make_down", key_down, 1'b1);
        chk("make_count", press_count, 8'd1);
        send(8'hF0); send(8'h1C);
        wait_idle();
        chk("break_flag", key_break, 1'b1);
        chk("break_down", key_down, 1'b0);
        chk("break_count", press_count, 8'd1);

        send(8'h1C); send(8'h1C); send(8'h1C);
        wait_idle();
        chk("repeat_flag", key_repeat, 1'b1);
        chk("repeat_count", press_count, 8'd2);
        send(8'hF0); send(8'h1C);

        send(8'h12); send(8'h1C);
        wait_idle();
        chk("shift_upper", key_ascii, 8'h41);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        wait_idle();
        chk("shift_xor_caps", key_ascii, 8'h61);
        chk("caps_set", caps_on, 1'b1);
        chk("shift_set", shift_on, 1'b1);

        send(8'hE0); send(8'h75);
        wait_idle();
        chk("ext_make", {key_ext, key_break, key_ascii}, {1'b1, 1'b0, 8'h00});
        send(8'hE0); send(8'hF0); send(8'h75);
        wait_idle();
        chk("ext_break", {key_ext, key_break, key_ascii}, {1'b1, 1'b1, 8'h00});
        e0 = n_err;
        send(8'hF0); send(8'hF0); send(8'h1C);
        wait_idle();
        chk("err_pulses", n_err - e0, 1);
        chk("after_err_make", {key_code, key_break}, {8'h1C, 1'b0});

        send(8'hF0); send(8'h1C);
        wait_idle();
        cb = press_count;
        bb = b_press_count;
        send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        lows = 0; cons = 0; prev = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (!nextdata_n) lows++;
            if (!nextdata_n && !prev) cons++;
            prev = nextdata_n;
        end
        chk("pop_count", lows, 4);
        chk("pop_back_to_back", cons, 0);
        wait_idle();
        chk("count_plus4", press_count, cb + 8'd4);
        chk("count_w2_wrap", b_press_count, bb);

        send(8'hE0);
        wait_idle();
        do_reset();
        send(8'h75);
        wait_idle();
        chk("post_reset_ext", {key_code, key_ext}, {8'h75, 1'b0});

        last = 8'h1C;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                wait_idle();
                do_reset();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = $urandom_range(0, 99);
            b = r < 8  ? 8'hE0 : r < 16 ? 8'hF0 : r < 26 ? mod_sc[$urandom_range(0, 2)] :
                r < 52 ? letter_sc[$urandom_range(0, 25)] : r < 64 ? digit_sc[$urandom_range(0, 9)] :
                r < 68 ? 8'h29 : r < 72 ? 8'h5A : r < 90 ? last : 8'($urandom);
            if (b != 8'hE0 && b != 8'hF0) last = b;
            send(b);
        end
        wait_idle();
        chk("scoreboard_drained", exq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
